alu_lockstep_monitor: RTL

ALU_LOCKSTEP_MONITOR -- requirements
Module: alu_lockstep_monitor

---
 rtl/alu_lockstep_monitor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_lockstep_monitor.sv
// alu_lockstep_monitor
//   Compares a golden ALU against a suspect ALU through a two-stage pipeline.
//   Stage 1 registers the sample. Stage 2 compares {result, carry, zero} and
//   updates the saturating counters, the monitor FSM and the optional mismatch log.
//
// Configuration macro: MISMATCH_LOG_EN
//   Defined   : builds a LOG_DEPTH-entry first-word-fall-through mismatch log.
//   Undefined : no log storage. log_empty is held at 1, log_overflow and
//               log_rd_data are held at 0, and log_rd_en is ignored.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   clear                          synchronous soft clear (highest priority)
//   in_valid                       qualifies a, b, op and both sets of results
//   a, b, op                       operands / opcode applied to both ALUs
//   res_*, cout_*, zf_*            golden (clean) and suspect (sus) outputs
//   test_count, mismatch_count     saturating sample / mismatch counters
//   trigger_count                  saturating count of known trigger patterns
//   mon_state, alarm               FSM state (IDLE/MONITOR/SUSPECT/ALARM), alarm flag
//   log_rd_en, log_rd_data         pop strobe, head entry {a,b,op,res_clean,res_sus}
//   log_empty, log_overflow        log empty flag, sticky entry-dropped flag
module alu_lockstep_monitor #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ALARM_THRESH = 1,
    parameter int unsigned LOG_DEPTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [1:0]       op,
    input  logic [3:0]       res_clean,
    input  logic [3:0]       res_sus,
    input  logic             cout_clean,
    input  logic             cout_sus,
    input  logic             zf_clean,
    input  logic             zf_sus,
    output logic [CNT_W-1:0] test_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [7:0]       trigger_count,
    output logic [1:0]       mon_state,
    output logic             alarm,
    input  logic             log_rd_en,
    output logic [17:0]      log_rd_data,
    output logic             log_empty,
    output logic             log_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        SUSPECT = 2'b10,
        ALARM   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

    // Stage 1 registers
    logic       s1_valid;
    logic [3:0] s1_a, s1_b, s1_res_clean, s1_res_sus;
    logic [1:0] s1_op;
    logic       s1_cout_clean, s1_cout_sus, s1_zf_clean, s1_zf_sus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_op         <= '0;
            s1_res_clean  <= '0;
            s1_res_sus    <= '0;
            s1_cout_clean <= 1'b0;
            s1_cout_sus   <= 1'b0;
            s1_zf_clean   <= 1'b0;
            s1_zf_sus     <= 1'b0;
        end else begin
            // A sample arriving together with clear is discarded.
            s1_valid      <= in_valid & ~clear;
            s1_a          <= a;
            s1_b          <= b;
            s1_op         <= op;
            s1_res_clean  <= res_clean;
            s1_res_sus    <= res_sus;
            s1_cout_clean <= cout_clean;
            s1_cout_sus   <= cout_sus;
            s1_zf_clean   <= zf_clean;
            s1_zf_sus     <= zf_sus;
        end
    end

    // Stage 2 compare
    logic             mism, trig;
    logic [CNT_W-1:0] test_next, mm_next;
    logic [7:0]       trig_next;

    always_comb begin
        mism = s1_valid &&
               ({s1_res_clean, s1_cout_clean, s1_zf_clean} !=
                {s1_res_sus,   s1_cout_sus,   s1_zf_sus});
        trig = s1_valid &&
               (((s1_a == 4'hF) && (s1_b == 4'hF) && (s1_op == 2'b00)) ||
                ((s1_a == 4'h0) && (s1_b == 4'hF) && (s1_op == 2'b10)));
        test_next = test_count;
        mm_next   = mismatch_count;
        trig_next = trigger_count;
        if (s1_valid && (test_count != '1))    test_next = test_count + CNT_ONE;
        if (mism && (mismatch_count != '1))    mm_next   = mismatch_count + CNT_ONE;
        if (trig && (trigger_count != 8'hFF))  trig_next = trigger_count + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_count     <= '0;
            mismatch_count <= '0;
            trigger_count  <= '0;
        end else if (clear) begin
            test_count     <= '0;
            mismatch_count <= '0;
            trigger_count  <= '0;
        end else begin
            test_count     <= test_next;
            mismatch_count <= mm_next;
            trigger_count  <= trig_next;
        end
    end

    // Monitor FSM
    state_t state, state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (mism && (mm_next >= THRESH)) begin
            // Judged on the post-update count so the alarm lands on the same
            // edge that counts the threshold-reaching mismatch.
            state_next = ALARM;
        end else if (s1_valid) begin
            case (state)
                IDLE:    state_next = mism ? SUSPECT : MONITOR;
                MONITOR: if (mism) state_next = SUSPECT;
                default: state_next = state;
            endcase
        end
    end

    assign mon_state = state;
    assign alarm     = (state == ALARM);

`ifdef MISMATCH_LOG_EN
    localparam int unsigned AW = $clog2(LOG_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [17:0] mem [LOG_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, do_rd, do_wr;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_rd = log_rd_en && !empty;
        // When full, a write is accepted only if a pop frees a slot this cycle.
        do_wr = mism && (!full || do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            log_overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (mism && !do_wr) log_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clear)
            mem[wr_ptr[AW-1:0]] <= {s1_a, s1_b, s1_op, s1_res_clean, s1_res_sus};
    end

    assign log_empty   = empty;
    assign log_rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
    logic unused_log_rd_en;
    assign unused_log_rd_en = log_rd_en;
    assign log_empty        = 1'b1;
    assign log_overflow     = 1'b0;
    assign log_rd_data      = '0;
`endif

endmodule
